// File: rtl/serial_rx9_bdeduffy_pkg.sv
// serial_rx9_bdeduffy_pkg: shared FSM encoding and frame constants for the 9-bit serial receiver
package serial_rx9_bdeduffy_pkg;
  localparam int FRAME_W = 9;
  localparam bit PARITY_ODD = 1'b1;
  localparam bit PARITY_EVEN = 1'b0;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_e;
endpackage

// File: rtl/sync_2ff_bdeduffy.sv
// sync_2ff_bdeduffy: two-flop synchroniser with configurable reset value
module sync_2ff_bdeduffy #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= {2{RST_VAL}};
    else ff_q <= {ff_q[0], d_i};
  end
  assign q_o = ff_q[1];
endmodule

// File: rtl/serial_rx9_bdeduffy.sv
// serial_rx9_bdeduffy: 1 start + 9 payload (LSB first) + 1 stop receiver feeding an external parity checker
module serial_rx9_bdeduffy
  import serial_rx9_bdeduffy_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit EXPECT_ODD = PARITY_ODD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_in,
  input  logic               parity_odd,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  input  logic               frame_ack,
  output logic               parity_err,
  output logic               framing_err,
  output logic               overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d, frame_q, frame_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d, load_q, load_d;
  logic rx_s, complete, bad_stop;
  sync_2ff_bdeduffy #(.RST_VAL(1'b1)) u_sync (
    .clk(clk), .rst_n(rst_n), .d_i(rx_in), .q_o(rx_s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    complete = 1'b0;
    bad_stop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? ST_IDLE : ST_START;
      end
      ST_START: if (cnt_q == CNT_MID) begin
        cnt_d = '0;
        state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[FRAME_W-1:1]};
        idx_d = idx_q + 4'd1;
        state_d = (idx_q == 4'd8) ? ST_STOP : ST_DATA;
      end
      ST_STOP: if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        complete = rx_s;
        bad_stop = !rx_s;
        state_d = rx_s ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        cnt_d = '0;
        state_d = rx_s ? ST_IDLE : ST_BREAK;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // The checker settles on frame_out for one full cycle (load_q) before its result is latched.
  always_comb begin
    load_d = complete && (!valid_q || frame_ack);
    frame_d = load_d ? shift_q : frame_q;
    valid_d = load_q ? 1'b1 : load_d ? valid_q : valid_q && !frame_ack;
    perr_d = load_q ? (parity_odd != EXPECT_ODD) : (valid_q && frame_ack && !load_d) ? 1'b0 : perr_q;
    ovr_d = complete && valid_q && !frame_ack;
    ferr_d = bad_stop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
      load_q <= load_d;
    end
  end
  assign frame_out = frame_q;
  assign frame_valid = valid_q;
  assign parity_err = perr_q;
  assign framing_err = ferr_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_serial_rx9_bdeduffy.sv
// tb_serial_rx9_bdeduffy: vector table, corner sequences and random frames against a frame-level model
module tb_serial_rx9_bdeduffy;
  localparam int C = 16;
  localparam int P = 10;
  typedef struct {
    logic [8:0] f;
    logic stop;
    logic ev;
    logic [8:0] eo;
    logic ep;
    int ef;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1, frame_ack = 1'b0;
  logic [8:0] frame_out;
  logic frame_valid, parity_err, framing_err, overrun, parity_odd;
  int total = 0, bad = 0, ferr_n = 0, ovr_n = 0, rise_n = 0;
  longint rise_t = 0, t0 = 0;
  logic v_prev = 1'b0;
  vec_t tbl[6];
  assign parity_odd = ^frame_out;
  always #(P/2) clk = ~clk;
  serial_rx9_bdeduffy #(.CLKS_PER_BIT(C), .EXPECT_ODD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .parity_odd(parity_odd),
    .frame_out(frame_out), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .parity_err(parity_err), .framing_err(framing_err), .overrun(overrun)
  );
  initial forever begin
    @(negedge clk);
    if (framing_err) ferr_n++;
    if (overrun) ovr_n++;
    if (frame_valid && !v_prev) begin
      rise_n++;
      rise_t = $time;
    end
    v_prev = frame_valid;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [8:0] f, input logic stop, input int extra);
    @(posedge clk);
    rx_in = 1'b0;
    t0 = $time;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      rx_in = f[i];
      repeat (C) @(posedge clk);
    end
    rx_in = stop;
    repeat (C + extra) @(posedge clk);
    rx_in = 1'b1;
  endtask
  task automatic do_ack(input string tag);
    @(posedge clk);
    frame_ack = 1'b1;
    @(posedge clk);
    frame_ack = 1'b0;
    @(negedge clk);
    check({tag, "_ack_valid"}, frame_valid, 0);
    check({tag, "_ack_perr"}, parity_err, 0);
  endtask
  task automatic run_frame(input string tag, input logic [8:0] f, input logic stop, input logic ev,
                           input logic [8:0] eo, input logic ep, input int ef);
    int f0, r0;
    f0 = ferr_n;
    r0 = rise_n;
    send(f, stop, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, frame_valid, ev);
    check({tag, "_out"}, frame_out, eo);
    check({tag, "_perr"}, parity_err, ep);
    check({tag, "_ferr"}, ferr_n - f0, ef);
    check({tag, "_rises"}, rise_n - r0, ev);
    if (ev) do_ack(tag);
  endtask
  initial begin
    int f0, o0, r0, lat;
    logic [8:0] model_out, f;
    logic stop;
    tbl[0] = '{9'h1A5, 1'b1, 1'b1, 9'h1A5, 1'b0, 0};
    tbl[1] = '{9'h0A5, 1'b1, 1'b1, 9'h0A5, 1'b1, 0};
    tbl[2] = '{9'h0FF, 1'b0, 1'b0, 9'h0A5, 1'b0, 1};
    tbl[3] = '{9'h100, 1'b1, 1'b1, 9'h100, 1'b0, 0};
    tbl[4] = '{9'h000, 1'b1, 1'b1, 9'h000, 1'b1, 0};
    tbl[5] = '{9'h1FF, 1'b1, 1'b1, 9'h1FF, 1'b0, 0};
    repeat (3) @(negedge clk);
    check("rst_out", frame_out, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", framing_err, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_frame("lat", 9'h1A5, 1'b1, 1'b1, 9'h1A5, 1'b0, 0);
    lat = int'((rise_t - t0) / P);
    check("latency_in_170_172", (lat >= 170 && lat <= 172), 1);
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].f, tbl[i].stop, tbl[i].ev, tbl[i].eo, tbl[i].ep, tbl[i].ef);
    o0 = ovr_n;
    r0 = rise_n;
    send(9'h1A5, 1'b1, 0);
    send(9'h003, 1'b1, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ovr_count", ovr_n - o0, 1);
    check("ovr_out", frame_out, 9'h1A5);
    check("ovr_valid", frame_valid, 1);
    check("ovr_perr", parity_err, 0);
    check("ovr_rises", rise_n - r0, 1);
    do_ack("ovr");
    f0 = ferr_n;
    r0 = rise_n;
    send(9'h0FF, 1'b0, 40 * C);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("brk_ferr", ferr_n - f0, 1);
    check("brk_rises", rise_n - r0, 0);
    check("brk_valid", frame_valid, 0);
    run_frame("brk_next", 9'h100, 1'b1, 1'b1, 9'h100, 1'b0, 0);
    f0 = ferr_n;
    o0 = ovr_n;
    r0 = rise_n;
    @(posedge clk);
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    rx_in = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_ferr", ferr_n - f0, 0);
    check("glitch_ovr", ovr_n - o0, 0);
    check("glitch_rises", rise_n - r0, 0);
    run_frame("glitch_next", 9'h0C3, 1'b1, 1'b1, 9'h0C3, 1'b1, 0);
    f = 9'h155;
    @(posedge clk);
    rx_in = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_in = f[i];
      repeat (i < 4 ? C : C / 2) @(posedge clk);
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mrst_out", frame_out, 0);
    check("mrst_valid", frame_valid, 0);
    check("mrst_perr", parity_err, 0);
    check("mrst_ferr", framing_err, 0);
    check("mrst_ovr", overrun, 0);
    rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_frame("mrst_next", 9'h155, 1'b1, 1'b1, 9'h155, 1'b0, 0);
    model_out = 9'h155;
    for (int i = 0; i < 10; i++) begin
      f = 9'($urandom_range(0, 511));
      stop = ($urandom_range(0, 7) != 0);
      run_frame($sformatf("rnd%0d", i), f, stop, stop, stop ? f : model_out,
                stop ? (($countones(f) % 2) != 1) : 1'b0, stop ? 0 : 1);
      if (stop) model_out = f;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
